program_loader: RTL and testbench
=================================

# program_loader

Boot-time writer for the instruction memory. It accepts a byte stream from the serial receiver, assembles little-endian 32-bit words and drives the instruction memory write port at consecutive word addresses. It holds the core in reset until a complete program has been loaded. It sits between the UART receiver and the instruction memory write port, and its core reset output gates the core's reset.

## Interface
Parameters:
- DEPTH, 1024: instruction memory depth in 32-bit words; maximum loadable program length.

Ports (clocking: one clock; reset is synchronous and active-high):
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse that begins a load.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  rx_data_i valid.
- rx_ready_o  out  1  loader accepts a byte this cycle.
- mem_we_o  out  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr_o  out  32  byte address of the write, always word-aligned (bits [1:0] = 0).
- mem_wdata_o  out  32  assembled word.
- core_reset_o  out  1  holds the core in reset while not DONE.
- busy_o  out  1  load in progress.
- done_o  out  1  program loaded successfully.
- error_o  out  1  load aborted.

## Operation
- Stream format: 4-byte word count N (little-endian), then N words of 4 bytes each, LSB first.
- Byte accepted when rx_valid_i && rx_ready_o.
- FSM states: IDLE, LEN, DATA, CHECK (only with the macro), DONE, ERROR.
- IDLE: start_i -> LEN; byte counter and word index cleared.
- LEN: after 4 bytes:
  - N > DEPTH -> ERROR (no writes).
  - N == 0 -> DONE (or CHECK with the macro).
  - else -> DATA.
- DATA: every 4th accepted byte completes a word.
  - The next cycle issues mem_we_o=1 with mem_addr_o = word_index*4 and mem_wdata_o = the assembled word.
  - Word index increments after each write.
  - After the N-th write -> DONE (or CHECK).
- DONE and ERROR: absorbing; start_i restarts from LEN and clears done_o/error_o.
- start_i in LEN/DATA/CHECK: ignored.
- rx_ready_o = 1 only in LEN, DATA and CHECK.
- busy_o = 1 in LEN, DATA and CHECK. done_o = 1 in DONE. error_o = 1 in ERROR.
- core_reset_o = 1 in every state except DONE.
- Word index width: clog2(DEPTH)+1. mem_addr_o is zero-extended index << 2. Bytes arriving beyond the stream are not accepted (rx_ready_o = 0).

## Timing
- Reset values: rx_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, core_reset_o=1, busy_o=0, done_o=0, error_o=0; state IDLE.
- All outputs are registered.
- start_i at cycle t: busy_o=1 and rx_ready_o=1 at t+1.
- Byte acceptance: at most 1 byte per cycle, no stall from the loader in LEN/DATA/CHECK. A byte may be accepted in the same cycle as a mem_we_o pulse.
- Write latency: 4th byte of a word accepted at t -> mem_we_o pulse at t+1.
- Completion: final mem_we_o at t -> done_o=1, core_reset_o=0, busy_o=0 at t+1.
- N == 0: done_o one cycle after the 4th header byte.
- Oversize N: error_o one cycle after the 4th header byte.
- reset_i mid-load: next cycle all outputs take their reset values and the FSM returns to IDLE. Words already written remain in memory; an incomplete word is discarded.

## Configuration
- PROGRAM_LOADER_CHECKSUM_EN defined:
  - A running XOR of all payload words is maintained (zero for N == 0).
  - After the payload, CHECK accepts 4 further bytes (little-endian word).
  - Match -> DONE; mismatch -> ERROR.
  - Memory writes are not undone on mismatch, but core_reset_o stays 1.
- Undefined: no CHECK state and no checksum bytes; DATA goes straight to DONE.

## Structure
- Package program_loader_pkg: state enum type, byte-per-word constant (4), word address shift constant (2).
- Sub-module word_assembler: 8-to-32 little-endian shift register with 2-bit byte counter and one-cycle word_valid output. Shared by the length, data and checksum phases.
- Top: FSM, word index counter, write port registers, checksum register.

## Test plan
- Header 02 00 00 00, words 0x00500093 and 0x00100113 (bytes LSB first) -> writes (addr 0x0, 0x00500093) then (addr 0x4, 0x00100113); done_o=1 and core_reset_o=0 the cycle after the second write.
- Header N=DEPTH+1 (0x401 at DEPTH 1024) -> error_o=1 one cycle after the 4th header byte, no mem_we_o, core_reset_o stays 1.
- Header N=0 -> done_o one cycle after the header, no writes; with the macro, checksum 00 00 00 00 is required first.
- rx_valid_i toggled every other cycle during a 3-word load -> same writes and addresses, one write pulse per word, no byte lost.
- reset_i asserted after 6 payload bytes -> word 0 written, next cycle state IDLE with all outputs at reset values; a new start_i with a full stream loads from address 0.
- Macro on: words 0x11111111, 0x22222222 with checksum 0x33333333 -> DONE; with checksum 0x33333334 -> ERROR and core_reset_o=1.

Source files
------------

// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_pkg
// Description : Shared types and constants for the boot-time program loader.
// Revision    : 1.0
// ============================================================================
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_SHIFT     = 2;

endpackage : program_loader_pkg
`default_nettype wire

// File: rtl/program_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Little-endian 8-to-32 assembler; word_valid_o pulses in the
//               cycle the fourth byte of a word is accepted.
// Revision    : 1.0
// ============================================================================
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [23:0] shreg_q, shreg_d;
    logic [1:0]  cnt_q, cnt_d;

    // The completed word is presented combinationally so the owner can
    // register it on the same edge that accepts the final byte.
    always_comb begin
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        word_o       = {byte_i, shreg_q};
        word_valid_o = byte_valid_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (byte_valid_i) begin
            shreg_d = {byte_i, shreg_q[23:8]};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : word_assembler
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Loads a length-prefixed byte stream into instruction memory
//               and holds the core in reset until the load completes.
//               Optional checksum phase: PROGRAM_LOADER_CHECKSUM_EN.
// Revision    : 1.0
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_reset_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int IDX_W = $clog2(DEPTH) + 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   widx_q, widx_d;
    logic [IDX_W-1:0]   len_q, len_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               rx_ready_q, rx_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               core_reset_q, core_reset_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0]        csum_q, csum_d;
`endif

    logic               byte_accept;
    logic               asm_clear;
    logic               word_valid;
    logic [31:0]        word;

    assign byte_accept = rx_valid_i && rx_ready_q;

    word_assembler u_word_assembler (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (asm_clear),
        .byte_valid_i (byte_accept),
        .byte_i       (rx_data_i),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        len_d       = len_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        asm_clear   = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    state_d   = ST_LEN;
                    widx_d    = '0;
                    len_d     = '0;
                    asm_clear = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            ST_LEN: begin
                if (word_valid) begin
                    if (word > 32'(DEPTH)) begin
                        state_d = ST_ERROR;
                    end else if (word == 32'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_DATA;
                        len_d   = word[IDX_W-1:0];
                    end
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = 32'(widx_q) << WORD_SHIFT;
                    mem_wdata_d = word;
                    widx_d      = widx_q + IDX_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ word;
`endif
                end else if (widx_q == len_q) begin
                    // Leave only after the final write pulse has been issued.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (word_valid) begin
                    state_d = (word == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        busy_d       = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHECK);
        done_d       = (state_d == ST_DONE);
        error_d      = (state_d == ST_ERROR);
        core_reset_d = (state_d != ST_DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        rx_ready_d   = busy_d;
`else
        // No bytes follow the last payload word, so refuse them during the
        // cycle of its write pulse.
        rx_ready_d   = busy_d && !((state_d == ST_DATA) && (widx_d == len_d));
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            widx_q       <= '0;
            len_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_reset_q <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            len_q        <= len_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rx_ready_q   <= rx_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            core_reset_q <= core_reset_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign rx_ready_o   = rx_ready_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign core_reset_o = core_reset_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule : program_loader
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Randomized self-checking bench for program_loader.
// Revision    : 1.0
// ============================================================================
module tb_program_loader;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o, mem_we_o, core_reset_o, busy_o, done_o, error_o;
    logic [31:0] mem_addr_o, mem_wdata_o;

    program_loader #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .rx_ready_o   (rx_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .core_reset_o (core_reset_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0]  stream_q[$];
    logic [31:0] word_q[$];
    int          acc_cyc[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          we_cyc[$];
    int          done_cyc = -1;
    int          err_cyc  = -1;
    logic        done_prev = 1'b0;
    logic        err_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we_o) begin
            got_addr.push_back(mem_addr_o);
            got_data.push_back(mem_wdata_o);
            we_cyc.push_back(cyc);
        end
        if (done_o && !done_prev) done_cyc = cyc;
        if (error_o && !err_prev) err_cyc = cyc;
        done_prev = done_o;
        err_prev  = error_o;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_capture();
        acc_cyc.delete();
        got_addr.delete();
        got_data.delete();
        we_cyc.delete();
        done_cyc = -1;
        err_cyc  = -1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) stream_q.push_back(w[8*b +: 8]);
    endtask

    // Stream = header N, payload (unless oversize), optional checksum word.
    task automatic build_stream(input int n, input bit corrupt);
        logic [31:0] x;
        stream_q.delete();
        push_word(32'(n));
        x = '0;
        if (n <= DEPTH) begin
            foreach (word_q[i]) begin
                push_word(word_q[i]);
                x ^= word_q[i];
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            push_word(corrupt ? x + 32'd1 : x);
`endif
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    // mode 0: continuous, 1: valid every other cycle, 2: random valid + stray start pulses
    task automatic send_bytes(input int max_n, input int mode);
        int idx   = 0;
        int guard = 0;
        int want  = (max_n < stream_q.size()) ? max_n : stream_q.size();
        while (idx < want && guard < 20000) begin
            rx_data_i = stream_q[idx];
            case (mode)
                0:       rx_valid_i = 1'b1;
                1:       rx_valid_i = (guard[0] == 1'b0);
                default: rx_valid_i = 1'($urandom_range(0, 1));
            endcase
            if (mode == 2) start_i = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (rx_valid_i) check_eq("rx_ready_in_stream", 32'(rx_ready_o), 32'd1);
            if (rx_valid_i && rx_ready_o) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            @(posedge clk); #1;
            guard++;
        end
        rx_valid_i = 1'b0;
        start_i    = 1'b0;
        check_eq("bytes_fed", 32'(idx), 32'(want));
    endtask

    task automatic run_load(input int n, input int mode, input bit corrupt);
        bit exp_err;
        int n_wr;
        int last;
        int fin;
        exp_err = (n > DEPTH);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        exp_err = exp_err || corrupt;
`endif
        n_wr = (n > DEPTH) ? 0 : n;
        build_stream(n, corrupt);
        clear_capture();
        pulse_start();
        send_bytes(stream_q.size(), mode);
        for (int i = 0; i < 20 && !(done_o || error_o); i++) @(negedge clk);
        check_eq("finished", 32'(done_o || error_o), 32'd1);
        @(posedge clk); #1;

        check_eq("write_count", 32'(got_addr.size()), 32'(n_wr));
        for (int k = 0; k < n_wr && k < got_addr.size(); k++) begin
            check_eq("wr_addr", got_addr[k], 32'(k * 4));
            check_eq("wr_data", got_data[k], word_q[k]);
            if (acc_cyc.size() > 4 * k + 7)
                check_eq("wr_latency", 32'(we_cyc[k]), 32'(acc_cyc[4 * k + 7] + 1));
        end

        last = acc_cyc.size() - 1;
        fin  = (last >= 0) ? acc_cyc[last] + 1 : -100;
`ifndef PROGRAM_LOADER_CHECKSUM_EN
        if (n_wr > 0) fin = fin + 1;
`endif
        check_eq("done_cycle", 32'(done_cyc), exp_err ? 32'hFFFF_FFFF : 32'(fin));
        check_eq("error_cycle", 32'(err_cyc), exp_err ? 32'(fin) : 32'hFFFF_FFFF);
        check_eq("done_o", 32'(done_o), 32'(!exp_err));
        check_eq("error_o", 32'(error_o), 32'(exp_err));
        check_eq("core_reset_o", 32'(core_reset_o), 32'(exp_err));
        check_eq("busy_end", 32'(busy_o), 32'd0);
        check_eq("rx_ready_end", 32'(rx_ready_o), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rx_ready"}, 32'(rx_ready_o), 32'd0);
        check_eq({tag, "_mem_we"}, 32'(mem_we_o), 32'd0);
        check_eq({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        check_eq({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
        check_eq({tag, "_core_reset"}, 32'(core_reset_o), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_done"}, 32'(done_o), 32'd0);
        check_eq({tag, "_error"}, 32'(error_o), 32'd0);
    endtask

    task automatic random_words(input int n);
        word_q.delete();
        for (int i = 0; i < n; i++) word_q.push_back($urandom);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;

        // Two-instruction program
        word_q = '{32'h0050_0093, 32'h0010_0113};
        run_load(2, 0, 1'b0);

        // Oversize header
        word_q.delete();
        run_load(DEPTH + 1, 0, 1'b0);

        // Empty program
        run_load(0, 0, 1'b0);

        // Sparse valid
        random_words(3);
        run_load(3, 1, 1'b0);

        // Reset after six payload bytes, then a clean reload
        random_words(3);
        build_stream(3, 1'b0);
        clear_capture();
        pulse_start();
        send_bytes(10, 0);
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        check_eq("midreset_writes", 32'(got_addr.size()), 32'd1);
        if (got_addr.size() > 0) begin
            check_eq("midreset_addr", got_addr[0], 32'd0);
            check_eq("midreset_data", got_data[0], word_q[0]);
        end
        @(posedge clk); #1;
        random_words(3);
        run_load(3, 0, 1'b0);

        // Checksum examples (plain loads when the checksum phase is absent)
        word_q = '{32'h1111_1111, 32'h2222_2222};
        run_load(2, 0, 1'b0);
        run_load(2, 0, 1'b1);

        // Largest legal program
        random_words(DEPTH);
        run_load(DEPTH, 0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            int n;
            n = $urandom_range(1, 8);
            random_words(n);
            run_load(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_program_loader
`default_nettype wire
